// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, valid/ready on
// both sides, 16 parallel inverse S-box ROMs and xtime-based InvMixColumns.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - ciphertext handshake; in_ready only in IDLE
//   d_in              - ciphertext, [127:120] = state byte 0, column-major
//   key_schedule      - 44 expanded key words, w[i][31:24] is row 0
//   out_valid/out_ready - plaintext handshake; out_valid held until taken
//   d_out             - plaintext, same byte order as d_in
//   busy              - high whenever the core is not IDLE

module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign o_byte = INV_SBOX[i_byte];
endmodule

module aes_decryption (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      d_in,
    input  logic [0:43][31:0] key_schedule,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      d_out,
    output logic              busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t       r_fsm;
    logic [127:0] r_state;
    logic [3:0]   r_rnd;
    logic [127:0] r_dout;
    logic         r_out_valid;

    logic [127:0] w_rk;
    logic [127:0] w_ark;
    logic [127:0] w_imc;
    logic [7:0]   w_isr [16];
    logic [7:0]   w_sub [16];
    logic [7:0]   w_x2  [16];
    logic [7:0]   w_x4  [16];
    logic [7:0]   w_x8  [16];
    logic [7:0]   w_m9  [16];
    logic [7:0]   w_mb  [16];
    logic [7:0]   w_md  [16];
    logic [7:0]   w_me  [16];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Round key words 4*rnd..4*rnd+3; rnd==0 in FINAL selects w0..w3.
    assign w_rk = {key_schedule[{r_rnd, 2'b00}],
                   key_schedule[{r_rnd, 2'b01}],
                   key_schedule[{r_rnd, 2'b10}],
                   key_schedule[{r_rnd, 2'b11}]};

    // Byte k = 4*col + row; InvShiftRows pulls row r from column (c - r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int K  = 4 * c + r;
            localparam int KS = 4 * ((c - r + 4) % 4) + r;

            assign w_isr[K] = r_state[127 - 8 * KS -: 8];

            aes_inv_sbox u_sbox (
                .i_byte (w_isr[K]),
                .o_byte (w_sub[K])
            );

            assign w_ark[127 - 8 * K -: 8] = w_sub[K] ^ w_rk[127 - 8 * K -: 8];

            assign w_x2[K] = xt(w_ark[127 - 8 * K -: 8]);
            assign w_x4[K] = xt(w_x2[K]);
            assign w_x8[K] = xt(w_x4[K]);
            assign w_m9[K] = w_x8[K] ^ w_ark[127 - 8 * K -: 8];
            assign w_mb[K] = w_x8[K] ^ w_x2[K] ^ w_ark[127 - 8 * K -: 8];
            assign w_md[K] = w_x8[K] ^ w_x4[K] ^ w_ark[127 - 8 * K -: 8];
            assign w_me[K] = w_x8[K] ^ w_x4[K] ^ w_x2[K];
        end
    end

    // Each output row r takes {e,b,d,9} from rows r, r+1, r+2, r+3.
    for (genvar c = 0; c < 4; c++) begin : g_mix_col
        for (genvar r = 0; r < 4; r++) begin : g_mix_row
            localparam int K0 = 4 * c + r;
            localparam int K1 = 4 * c + (r + 1) % 4;
            localparam int K2 = 4 * c + (r + 2) % 4;
            localparam int K3 = 4 * c + (r + 3) % 4;

            assign w_imc[127 - 8 * K0 -: 8] =
                w_me[K0] ^ w_mb[K1] ^ w_md[K2] ^ w_m9[K3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_rnd       <= '0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= d_in ^ {key_schedule[40], key_schedule[41],
                                           key_schedule[42], key_schedule[43]};
                        r_rnd   <= 4'd9;
                        r_fsm   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_state <= w_imc;
                    r_rnd   <= r_rnd - 4'd1;
                    if (r_rnd == 4'd1) begin
                        r_fsm <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_dout      <= w_ark;
                    r_out_valid <= 1'b1;
                    r_fsm       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign busy      = (r_fsm != S_IDLE);
    assign out_valid = r_out_valid;
    assign d_out     = r_dout;

endmodule

// File: tb/tb_aes_decryption.sv
// Bench for aes_decryption: known-answer vectors plus random round trips
// through a forward-cipher model built from GF(2^8) arithmetic.

module tb_aes_decryption;
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [127:0]      d_in;
    logic [0:43][31:0] ks;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      d_out;
    logic              busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [256];

    always #5 clk = ~clk;

    aes_decryption dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .d_in         (d_in),
        .key_schedule (ks),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .d_out        (d_out),
        .busy         (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15 - n -: 8];
    endfunction

    // Forward S-box: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0) begin
                for (int b = 1; b < 256; b++) begin
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
                end
            end
            sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                  ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) ks[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = ks[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
                  ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            ks[i] = ks[i - 4] ^ t;
        end
    endtask

    function automatic logic [127:0] rk(input int r);
        return {ks[4 * r], ks[4 * r + 1], ks[4 * r + 2], ks[4 * r + 3]};
    endfunction

    function automatic logic [127:0] subb(input logic [127:0] x);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = sb[x[127 - 8 * k -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shr(input logic [127:0] x);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] =
                    x[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mixc(input logic [127:0] x);
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [127:0] o;
        m = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(m[(j - r + 4) % 4], x[127 - 8 * (4 * c + j) -: 8]);
                o[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk(0);
        for (int r = 1; r < 10; r++) s = mixc(shr(subb(s))) ^ rk(r);
        return shr(subb(s)) ^ rk(10);
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [127:0] ct);
        int n;
        d_in = ct;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("acc_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run(input string tag, input logic [127:0] ct,
                       input logic [127:0] pt, input bit lat);
        int n;
        accept(ct);
        wait_out(n);
        if (lat) chk({tag, "_lat"}, 128'(n), 128'd10);
        chk(tag, d_out, pt);
        out_ready = 1'b1;
        tick();
        chk({tag, "_hs"}, 128'({in_ready, out_valid}), 128'b10);
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] pt2;
        logic [127:0] pts [3];
        logic [127:0] cts [3];
        logic [7:0]   pfx [4];
        logic         ok;
        int           n;
        int           na;
        int           nout;
        int           e;
        int           acc_e [3];
        logic         wa;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        d_in = '0;
        ks = '0;
        build_sbox();
        tick();
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_d_out", d_out, 128'h0);
        chk("rst_busy", 128'(busy), 128'd0);
        rst = 1'b0;
        tick();

        expand(KEY_B);
        run("appB", CT_B, PT_B, 1'b1);

        expand(128'h000102030405060708090a0b0c0d0e0f);
        run("appC1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
            128'h00112233445566778899aabbccddeeff, 1'b0);

        expand(128'h6c756b65696d796f7572666174686572);
        pfx = '{8'h61, 8'ha1, 8'hb1, 8'hc1};
        for (int i = 0; i < 4; i++) begin
            pt = {pfx[i], 120'h62636465666768696a6b6c7a7a7a7a};
            run("luke", enc(pt), pt, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            pt = {$urandom, $urandom, $urandom, $urandom};
            run("rand", enc(pt), pt, 1'b1);
        end

        // reset together with in_valid: nothing accepted
        rst = 1'b1;
        in_valid = 1'b1;
        d_in = {$urandom, $urandom, $urandom, $urandom};
        tick();
        chk("rstv_idle", 128'({in_ready, busy}), 128'b10);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rstv_still_idle", 128'({in_ready, busy}), 128'b10);

        // backpressure
        expand(KEY_B);
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        accept(CT_B);
        wait_out(n);
        chk("bp_first", d_out, PT_B);
        d_in = enc(pt2);
        in_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (d_out !== PT_B || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        end
        chk("bp_stable", 128'(ok), 128'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle", 128'({in_ready, out_valid}), 128'b10);
        tick();
        in_valid = 1'b0;
        chk("bp_accept", 128'(busy), 128'd1);
        wait_out(n);
        chk("bp_second_lat", 128'(n), 128'd10);
        chk("bp_second", d_out, pt2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset mid-round, sampled at E5
        accept(CT_B);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ov", 128'(out_valid), 128'd0);
        chk("mid_rst_dout", d_out, 128'h0);
        chk("mid_rst_ready", 128'(in_ready), 128'd1);
        run("after_rst", CT_B, PT_B, 1'b1);

        // key schedule changing mid-operation: completes with no X
        accept({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 44; i++) ks[i] = $urandom;
        wait_out(n);
        chk("kc_done", 128'(out_valid), 128'd1);
        chk("kc_nox", 128'($isunknown(d_out)), 128'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // back-to-back with out_ready held high
        key = {$urandom, $urandom, $urandom, $urandom};
        expand(key);
        for (int i = 0; i < 3; i++) begin
            pts[i] = {$urandom, $urandom, $urandom, $urandom};
            cts[i] = enc(pts[i]);
            acc_e[i] = -1;
        end
        out_ready = 1'b1;
        d_in = cts[0];
        in_valid = 1'b1;
        na = 0;
        nout = 0;
        e = 0;
        while (nout < 3 && e < 80) begin
            wa = in_ready && in_valid;
            tick();
            if (wa && na < 3) begin
                acc_e[na] = e;
                na++;
                if (na < 3) d_in = cts[na];
                else in_valid = 1'b0;
            end
            if (out_valid && nout < 3) begin
                chk("b2b_pt", d_out, pts[nout]);
                nout++;
            end
            e++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 128'(nout), 128'd3);
        for (int i = 0; i < 3; i++) chk("b2b_accept_edge", 128'(acc_e[i]), 128'(12 * i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_decryption.md
# aes_decryption

Iterative AES-128 decryption core: inverse cipher per FIPS-197 §5.3, one inverse round per clock, using the same expanded key schedule the team's `encryption` pipeline consumes. It sits on the receive side of the datapath, after the ciphertext source and ahead of the plaintext consumer. Both sides are valid/ready handshaked. Its output must reproduce the original block for any ciphertext produced by `encryption` under the same key schedule.

## Interface
Parameters:
- none (AES-128 only: Nk=4, Nr=10, 44 key words)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `d_in` holds a ciphertext block
- `in_ready`  out  1  core idle, can accept a block
- `d_in`  in  128  ciphertext block; `[127:120]` = state byte 0 (row 0, col 0), column-major per FIPS-197
- `key_schedule`  in  [0:43][31:0]  expanded key
  - `w[i][31:24]` is row 0
  - same packing as `encryption`
  - not latched: must be stable from the accept edge until `out_valid` rises
- `out_valid`  out  1  `d_out` holds a plaintext block
- `out_ready`  in  1  consumer takes `d_out`
- `d_out`  out  128  plaintext block, same byte order as `d_in`
- `busy`  out  1  high in ROUND, FINAL and DONE

## Operation
States:
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: load `state ← d_in ^ {w40,w41,w42,w43}`, set `rnd ← 9`, go to ROUND.
- **ROUND**
  - `state ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), {w[4·rnd]..w[4·rnd+3]}))`, then `rnd ← rnd−1`.
  - When `rnd`==1 is processed, go to FINAL.
- **FINAL**
  - `d_out ← AddRoundKey(InvSubBytes(InvShiftRows(state)), {w0..w3})`.
  - `out_valid ← 1`, go to DONE.
- **DONE**
  - Hold `d_out` and `out_valid`.
  - On `out_ready`: `out_valid ← 0`, go to IDLE.

Datapath:
- 16 parallel instances of an inverse S-box ROM (256 entries, FIPS-197 Fig. 14), all inside the block.
- InvMixColumns uses GF(2^8) xtime chains for ×9, ×b, ×d, ×e, reducing with 0x1b.
- `rnd` is a 4-bit down-counter and selects key words `4·rnd`..`4·rnd+3` with a combinational mux.
- `in_ready` = (state==IDLE). `busy` = !IDLE. Both are decoded from registered state.
- `d_out` is updated only in FINAL; it holds its value otherwise, including after the DONE handshake.

Boundary conditions:
- `in_valid` while not IDLE: ignored. The block is not queued; the source must hold it.
- `out_ready` high before `out_valid`: no effect.
- `out_ready` low in DONE: stall indefinitely. `d_out` and `out_valid` remain stable.
- `rst` in any state: at the next edge the core goes to IDLE, `out_valid`=0, `d_out`=0, `rnd`=0. Any in-flight block is discarded.
- `rst` together with `in_valid`: reset wins and nothing is accepted.
- `key_schedule` changing mid-operation: the result is undefined. Verification checks that no X appears and the FSM still completes.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `d_out`=128'h0, `busy`=0.
- Accept at edge E0. ROUND occupies edges E1–E9 and FINAL is E10. `out_valid` is high after E10, so latency is 10 cycles.
- With `out_ready` held high:
  - the handshake completes at E11 and `in_ready` is high after E11;
  - the next accept is at E12, giving throughput of 1 block per 12 cycles.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Test plan
- **FIPS-197 App. B:** key 2b7e151628aed2a6abf7158809cf4f3c expanded; `d_in`=3925841d02dc09fbdc118597196a0b32 → `d_out`=3243f6a8885a308d313198a2e0370734, with `out_valid` rising exactly 10 cycles after accept.
- **FIPS-197 App. C.1:** key 000102…0f; `d_in`=69c4e0d86a7b0430d8cdb78070b4c55a → `d_out`=00112233445566778899aabbccddeeff.
- **Round trip:** the team's `encryption` block uses key "lukeimyourfather" (w0=6c756b65…w43=a4405979) on inputs 6162…7a7a7a7a and a162…/b162…/c162…7a7a7a7a. Each ciphertext fed back through this core → the original block.
- **Backpressure:** `out_ready`=0 for 20 cycles after `out_valid` → `d_out` stable, `in_ready`=0, and a second `in_valid` is ignored. Raising `out_ready` → IDLE next cycle, then the second block is accepted.
- **Reset mid-round:** assert `rst` at E5 for 1 cycle → next cycle `out_valid`=0, `d_out`=0, `in_ready`=1. A fresh App. B block then decrypts correctly.
- **Back-to-back:** with `out_ready`=1 and `in_valid` held, three blocks are accepted at edges E0, E12 and E24, each producing correct plaintext.
